// File: rtl/cu_pkg.sv
// ISA opcodes, sequencer states, datapath mux selects and control-word layout
// for the 8-bit accumulator sequencer.
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JP   = 4'h8;
  localparam logic [3:0] OP_ALU  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] MUX_SHIFT = 2'b00;
  localparam logic [1:0] MUX_RF    = 2'b01;
  localparam logic [1:0] MUX_IN    = 2'b10;
  localparam logic [1:0] MUX_IMM   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FETCH2,
    ST_EXEC,
    ST_WAIT_IN,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] muxsel;
    logic [7:0] imm;
    logic       accwr;
    logic [2:0] rfaddr;
    logic       rfwr;
    logic [2:0] alusel;
    logic [1:0] shiftsel;
    logic       outen;
  } ctrl_t;

  function automatic logic [3:0] ir_opcode(input logic [7:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [2:0] ir_reg(input logic [7:0] ir);
    return ir[2:0];
  endfunction

  function automatic logic [2:0] b2_alusel(input logic [7:0] b2);
    return b2[4:2];
  endfunction

  function automatic logic [1:0] b2_shiftsel(input logic [7:0] b2);
    return b2[1:0];
  endfunction

  function automatic logic has_operand(input logic [7:0] ir);
    case (ir_opcode(ir))
      OP_LDI, OP_JMP, OP_JZ, OP_JP, OP_ALU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of an instruction byte and its operand into the EXEC
// control word, plus operand-length and jump-taken indications.
module cu_decode
  import cu_pkg::*;
(
  input  logic [7:0] ir,
  input  logic [7:0] operand,
  input  logic       z_q,
  input  logic       p_q,
  output ctrl_t      ctrl,
  output logic       is_2byte,
  output logic       is_jump
);

  always_comb begin
    ctrl     = '0;
    is_jump  = 1'b0;
    is_2byte = has_operand(ir);
    case (ir_opcode(ir))
      OP_LDA: begin
        ctrl.muxsel = MUX_RF;
        ctrl.rfaddr = ir_reg(ir);
        ctrl.accwr  = 1'b1;
      end
      OP_STA: begin
        ctrl.rfaddr = ir_reg(ir);
        ctrl.rfwr   = 1'b1;
      end
      OP_LDI: begin
        ctrl.muxsel = MUX_IMM;
        ctrl.imm    = operand;
        ctrl.accwr  = 1'b1;
      end
      OP_ALU: begin
        ctrl.muxsel   = MUX_SHIFT;
        ctrl.rfaddr   = ir_reg(ir);
        ctrl.alusel   = b2_alusel(operand);
        ctrl.shiftsel = b2_shiftsel(operand);
        ctrl.accwr    = 1'b1;
      end
      OP_OUT: ctrl.outen = 1'b1;
      OP_JMP: is_jump = 1'b1;
      OP_JZ:  is_jump = z_q;
      OP_JP:  is_jump = p_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Accumulator sequencer: req/ack fetch of 1-2 instruction bytes, then a single EXEC cycle.
// Ack stalls hold FETCH/FETCH2 with the address stable; WAIT_IN holds until in_valid.
module control_unit
  import cu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_cu,
  input  logic            rst_n_cu,
  output logic            pm_req_cu,
  output logic [PC_W-1:0] pm_addr_cu,
  input  logic            pm_ack_cu,
  input  logic [7:0]      pm_data_cu,
  input  logic            zero_cu,
  input  logic            positive_cu,
  output logic [1:0]      muxsel_cu,
  output logic [7:0]      imm_cu,
  output logic            accwr_cu,
  output logic [2:0]      rfaddr_cu,
  output logic            rfwr_cu,
  output logic [2:0]      alusel_cu,
  output logic [1:0]      shiftsel_cu,
  output logic            outen_cu,
  input  logic            in_valid_cu,
  output logic            in_ready_cu,
  output logic            halted_cu
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      ir_q, ir_d, opd_q, opd_d, dec_ir;
  logic            z_q, p_q, run_q;
  ctrl_t           dec_ctrl, cw;
  logic            dec_2byte, dec_jump;

  assign pc_inc = pc_q + PC_W'(1);
  // While fetching, classify the byte arriving on the bus rather than the stale IR.
  assign dec_ir = (state_q == ST_FETCH) ? pm_data_cu : ir_q;

  cu_decode u_decode (
    .ir       (dec_ir),
    .operand  (opd_q),
    .z_q      (z_q),
    .p_q      (p_q),
    .ctrl     (dec_ctrl),
    .is_2byte (dec_2byte),
    .is_jump  (dec_jump)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    opd_d       = opd_q;
    pm_req_cu   = 1'b0;
    cw          = '0;
    in_ready_cu = 1'b0;
    halted_cu   = 1'b0;
    // run_q keeps every output quiet until the first edge after reset release.
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          pm_req_cu = 1'b1;
          if (pm_ack_cu) begin
            ir_d = pm_data_cu;
            pc_d = pc_inc;
            if (dec_2byte)                            state_d = ST_FETCH2;
            else if (ir_opcode(pm_data_cu) == OP_IN)   state_d = ST_WAIT_IN;
            else if (ir_opcode(pm_data_cu) == OP_HALT) state_d = ST_HALT;
            else                                       state_d = ST_EXEC;
          end
        end
        ST_FETCH2: begin
          pm_req_cu = 1'b1;
          if (pm_ack_cu) begin
            opd_d   = pm_data_cu;
            pc_d    = pc_inc;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          cw = dec_ctrl;
          if (dec_jump) pc_d = PC_W'(opd_q);
          state_d = ST_FETCH;
        end
        ST_WAIT_IN: begin
          in_ready_cu = 1'b1;
          cw.muxsel   = MUX_IN;
          if (in_valid_cu) begin
            cw.accwr = 1'b1;
            state_d  = ST_FETCH;
          end
        end
        ST_HALT:  halted_cu = 1'b1;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  assign pm_addr_cu  = pm_req_cu ? pc_q : '0;
  assign muxsel_cu   = cw.muxsel;
  assign imm_cu      = cw.imm;
  assign accwr_cu    = cw.accwr;
  assign rfaddr_cu   = cw.rfaddr;
  assign rfwr_cu     = cw.rfwr;
  assign alusel_cu   = cw.alusel;
  assign shiftsel_cu = cw.shiftsel;
  assign outen_cu    = cw.outen;

  always_ff @(posedge clk_cu or negedge rst_n_cu) begin
    if (!rst_n_cu) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      opd_q   <= '0;
      z_q     <= 1'b1;
      p_q     <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opd_q   <= opd_d;
      run_q   <= 1'b1;
      if (cw.accwr) begin
        z_q <= zero_cu;
        p_q <= positive_cu;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized and directed bench for control_unit against an instruction-level model.
module tb_control_unit;

  logic       clk_cu = 1'b0;
  logic       rst_n_cu;
  logic       pm_req_cu;
  logic [7:0] pm_addr_cu;
  logic       pm_ack_cu;
  logic [7:0] pm_data_cu;
  logic       zero_cu, positive_cu;
  logic [1:0] muxsel_cu;
  logic [7:0] imm_cu;
  logic       accwr_cu;
  logic [2:0] rfaddr_cu;
  logic       rfwr_cu;
  logic [2:0] alusel_cu;
  logic [1:0] shiftsel_cu;
  logic       outen_cu;
  logic       in_valid_cu;
  logic       in_ready_cu;
  logic       halted_cu;

  always #5 clk_cu = ~clk_cu;

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk_cu(clk_cu), .rst_n_cu(rst_n_cu),
    .pm_req_cu(pm_req_cu), .pm_addr_cu(pm_addr_cu),
    .pm_ack_cu(pm_ack_cu), .pm_data_cu(pm_data_cu),
    .zero_cu(zero_cu), .positive_cu(positive_cu),
    .muxsel_cu(muxsel_cu), .imm_cu(imm_cu), .accwr_cu(accwr_cu),
    .rfaddr_cu(rfaddr_cu), .rfwr_cu(rfwr_cu), .alusel_cu(alusel_cu),
    .shiftsel_cu(shiftsel_cu), .outen_cu(outen_cu),
    .in_valid_cu(in_valid_cu), .in_ready_cu(in_ready_cu), .halted_cu(halted_cu)
  );

  int n_chk = 0, n_pass = 0;
  logic [7:0] mem [256];
  bit ack_rand, in_rand, flag_rand;
  int hold_cnt, rdy_cnt;

  // Observation logs for the literal checks
  logic [7:0]  addr_q [$];
  int          addr_cyc [$];
  logic [31:0] ev_q [$];
  int          ev_cyc [$];
  int          halt_cnt, cyc;

  // Instruction-level reference state
  logic [7:0]  m_pc, m_ir, m_opd;
  bit          m_z, m_p, m_halt, m_exec, m_wait, m_need_op, m_live;
  logic [31:0] obs, expv;
  logic [20:0] cw;
  logic [7:0]  b;
  bit          req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic logic [20:0] mk_cw(input logic [1:0] mux, input logic [7:0] imm,
      input logic accwr, input logic [2:0] rf, input logic rfwr, input logic [2:0] alu,
      input logic [1:0] sh, input logic outen);
    return {mux, imm, accwr, rf, rfwr, alu, sh, outen};
  endfunction

  function automatic logic [31:0] mk_ev(input logic [20:0] c, input logic inrdy);
    return {1'b0, 8'h00, c, inrdy, 1'b0};
  endfunction

  // Control word each opcode must issue in its execute cycle
  function automatic logic [20:0] isa_ctrl(input logic [7:0] ir, input logic [7:0] opd);
    case (ir[7:4])
      4'h1:    return mk_cw(2'd1, 8'd0, 1'b1, ir[2:0], 1'b0, 3'd0, 2'd0, 1'b0);
      4'h2:    return mk_cw(2'd0, 8'd0, 1'b0, ir[2:0], 1'b1, 3'd0, 2'd0, 1'b0);
      4'h3:    return mk_cw(2'd3, opd, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
      4'h5:    return mk_cw(2'd0, 8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1);
      4'hA:    return mk_cw(2'd0, 8'd0, 1'b1, ir[2:0], 1'b0, opd[4:2], opd[1:0], 1'b0);
      default: return 21'd0;
    endcase
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    if (i < addr_q.size()) return {24'd0, addr_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acyc_at(input int i);
    if (i < addr_cyc.size()) return 32'(addr_cyc[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ecyc_at(input int i);
    if (i < ev_cyc.size()) return 32'(ev_cyc[i]);
    return 32'hFFFF_FFFF;
  endfunction

  always @(negedge clk_cu) begin
    obs = {pm_req_cu, pm_addr_cu, muxsel_cu, imm_cu, accwr_cu, rfaddr_cu, rfwr_cu,
           alusel_cu, shiftsel_cu, outen_cu, in_ready_cu, halted_cu};
    if (!rst_n_cu) begin
      chk("reset_outputs", obs, 32'h0);
      m_pc = 8'h00; m_ir = 8'h00; m_opd = 8'h00; m_z = 1'b1; m_p = 1'b1;
      m_halt = 1'b0; m_exec = 1'b0; m_wait = 1'b0; m_need_op = 1'b0; m_live = 1'b0;
    end else if (!m_live) begin
      chk("release_outputs", obs, 32'h0);
      m_live = 1'b1;
      cyc = 0;
    end else begin
      cyc++;
      cw = 21'd0;
      if (m_exec)      cw = isa_ctrl(m_ir, m_opd);
      else if (m_wait) cw = mk_cw(2'd2, 8'd0, in_valid_cu, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
      req  = !(m_exec || m_wait || m_halt);
      expv = {req, req ? m_pc : 8'h00, cw, m_wait, m_halt};
      chk("cycle_outputs", obs, expv);
      if (pm_req_cu && pm_ack_cu) begin addr_q.push_back(pm_addr_cu); addr_cyc.push_back(cyc); end
      if (obs[22:2] != 21'd0 || in_ready_cu) begin ev_q.push_back(obs); ev_cyc.push_back(cyc); end
      if (halted_cu && !pm_req_cu) halt_cnt++;
      // advance the reference by what this cycle accomplished
      if (m_exec) begin
        if (m_ir[7:4] == 4'h6 || (m_ir[7:4] == 4'h7 && m_z) || (m_ir[7:4] == 4'h8 && m_p))
          m_pc = m_opd;
        m_exec = 1'b0;
      end else if (m_wait) begin
        if (in_valid_cu) m_wait = 1'b0;
      end else if (!m_halt && pm_ack_cu) begin
        b = mem[m_pc];
        m_pc = m_pc + 8'd1;
        if (m_need_op) begin
          m_opd = b; m_need_op = 1'b0; m_exec = 1'b1;
        end else begin
          m_ir = b;
          case (b[7:4])
            4'h3, 4'h6, 4'h7, 4'h8, 4'hA: m_need_op = 1'b1;
            4'h4:    m_wait = 1'b1;
            4'hF:    m_halt = 1'b1;
            default: m_exec = 1'b1;
          endcase
        end
      end
      if (cw[10]) begin m_z = zero_cu; m_p = positive_cu; end
    end
  end

  task automatic drive();
    pm_ack_cu = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (hold_cnt > 0 && pm_req_cu) begin pm_ack_cu = 1'b0; hold_cnt--; end
    pm_data_cu = mem[pm_addr_cu];
    if (in_ready_cu) rdy_cnt++; else rdy_cnt = 0;
    in_valid_cu = in_rand ? ($urandom_range(0, 3) == 0) : (in_ready_cu && rdy_cnt >= 6);
    zero_cu     = flag_rand ? 1'($urandom) : (imm_cu == 8'h00);
    positive_cu = flag_rand ? 1'($urandom) : !imm_cu[7];
  endtask

  task automatic step();
    @(posedge clk_cu);
    #1;
    drive();
  endtask

  task automatic run_prog(input int max_cyc);
    rst_n_cu = 1'b0;
    repeat (3) step();
    addr_q.delete(); addr_cyc.delete(); ev_q.delete(); ev_cyc.delete();
    halt_cnt = 0;
    rst_n_cu = 1'b1;
    for (int i = 0; i < max_cyc && halt_cnt < 20; i++) step();
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  initial begin
    rst_n_cu = 1'b0; pm_ack_cu = 1'b0; pm_data_cu = 8'h00; zero_cu = 1'b0;
    positive_cu = 1'b0; in_valid_cu = 1'b0;
    ack_rand = 1'b0; in_rand = 1'b0; flag_rand = 1'b0; hold_cnt = 0; rdy_cnt = 0;
    cyc = 0; halt_cnt = 0;

    // LDI 05; STA r3
    fill_halt(); mem[0] = 8'h30; mem[1] = 8'h05; mem[2] = 8'h23;
    run_prog(200);
    chk("first_addr", addr_at(0), 32'h00);
    chk("first_req_cycle", acyc_at(0), 32'd1);
    chk("addr_seq1", addr_at(1), 32'h01);
    chk("addr_seq2", addr_at(2), 32'h02);
    chk("ldi_word", ev_at(0), mk_ev(mk_cw(2'd3, 8'h05, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0), 1'b0));
    chk("ldi_latency", ecyc_at(0), 32'd3);
    chk("sta_word", ev_at(1), mk_ev(mk_cw(2'd0, 8'h00, 1'b0, 3'd3, 1'b1, 3'd0, 2'd0, 1'b0), 1'b0));
    chk("sta_latency", ecyc_at(1), 32'd5);
    chk("halt_reached1", {31'd0, halt_cnt >= 20}, 32'd1);

    // ALU r2, 01
    fill_halt(); mem[0] = 8'hA2; mem[1] = 8'h01;
    run_prog(200);
    chk("alu_word", ev_at(0), mk_ev(mk_cw(2'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0, 2'd1, 1'b0), 1'b0));
    chk("alu_one_cycle", 32'(ev_q.size()), 32'd1);

    // Conditional jumps
    fill_halt(); mem[0] = 8'h30; mem[1] = 8'h00; mem[2] = 8'h70; mem[3] = 8'h10;
    run_prog(200);
    chk("jz_taken", addr_at(4), 32'h10);
    fill_halt(); mem[0] = 8'h30; mem[1] = 8'h80; mem[2] = 8'h70; mem[3] = 8'h10;
    run_prog(200);
    chk("jz_not_taken", addr_at(4), 32'h04);
    fill_halt(); mem[0] = 8'h30; mem[1] = 8'h80; mem[2] = 8'h80; mem[3] = 8'h10;
    run_prog(200);
    chk("jp_not_taken", addr_at(4), 32'h04);

    // IN with in_valid late, then OUT
    fill_halt(); mem[0] = 8'h40; mem[1] = 8'h50;
    run_prog(200);
    chk("in_wait_word", ev_at(4), mk_ev(mk_cw(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0), 1'b1));
    chk("in_accept_word", ev_at(5), mk_ev(mk_cw(2'd2, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0), 1'b1));
    chk("in_accept_cycle", ecyc_at(5), 32'd7);
    chk("out_word", ev_at(6), mk_ev(mk_cw(2'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1), 1'b0));

    // Ack stall, PC wrap FF->00, halt
    fill_halt(); mem[0] = 8'h70; mem[1] = 8'hFE; mem[8'hFE] = 8'h30; mem[8'hFF] = 8'h80;
    hold_cnt = 4;
    run_prog(300);
    chk("stalled_first_ack", acyc_at(0), 32'd5);
    chk("jz_initial_flag", addr_at(2), 32'hFE);
    chk("pc_wrap", addr_at(4), 32'h00);
    chk("after_wrap_seq", addr_at(6), 32'h02);
    chk("halt_reached2", {31'd0, halt_cnt >= 20}, 32'd1);

    // Reset while in FETCH2
    hold_cnt = 0;
    run_prog(2);
    run_prog(300);
    chk("restart_addr", addr_at(0), 32'h00);
    chk("restart_cycle", acyc_at(0), 32'd1);

    // Random programs with random ack/in_valid/flags and resets at arbitrary points
    ack_rand = 1'b1; in_rand = 1'b1; flag_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hF && $urandom_range(0, 15) != 0) b[7:4] = 4'h0;
        mem[i] = b;
      end
      run_prog(int'($urandom_range(10, 400)));
    end
    rst_n_cu = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
